// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: drives stage enables and flushes, plus a data-memory watchdog.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             id_jump,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic             mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WMAX   = WCNT_W'(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WMAX_1 = WCNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        TIMEOUT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic              freeze;
    logic              load_use;

    assign freeze   = (state_q != RUN) || (mem_access && !dmem_ready);
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // Single priority chain: freeze > taken branch > load-use > jump.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = dmem_ready;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    // The RUN cycle that first sees not-ready counts as wait cycle 1.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_d = MEMWAIT;
                    wcnt_d  = WCNT_W'(1);
                end else begin
                    wcnt_d = '0;
                end
            end
            MEMWAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q >= WMAX_1) begin
                    state_d   = TIMEOUT;
                    wcnt_d    = WMAX;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            TIMEOUT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en)
                stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush || idex_flush || exmem_flush)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (WAIT_MAX=4); control vector order is
// {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_memread, id_jump, mem_branch_taken, mem_access, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [1:0] state;
    logic       mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
    int          exp_stall = 0;
    int          exp_flush = 0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_MAX(4), .CNT_W(16)) dut (
        .clk(clk), .res(res),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_jump(id_jump),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .state(state), .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    wire [7:0] ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s obs=%0h exp=%0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs for this cycle, then advance one clock.
    task automatic step(input string tag, input logic [7:0] exp_ctl, input logic [1:0] exp_state);
        #1;
        chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        chk({tag, ".st"}, 32'(state), 32'(exp_state));
`ifdef HAZ_PERF_CNT_EN
        if (!exp_ctl[7]) exp_stall++;
        if (exp_ctl[2:0] != 3'b000) exp_flush++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rt = 1'b0; ex_memread = 1'b0; id_jump = 1'b0;
        mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        idle();
        res = 1'b0;
        #12;
        chk("rst.ctl", 32'(ctl), 32'h0F8);
        chk("rst.st", 32'(state), 32'd0);
        chk("rst.tmo", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;

        // load-use on rt
        ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b1;
        step("lu_rt", 8'b00111_010, 2'd0);
        idle();
        step("lu_after", 8'b11111_000, 2'd0);

        // rt match ignored when the instruction does not read rt
        ex_memread = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd2; id_uses_rt = 1'b0;
        step("lu_no_rt", 8'b11111_000, 2'd0);
        id_rs = 5'd7;
        step("lu_rs", 8'b00111_010, 2'd0);

        // load to register 0 never stalls
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        step("reg0", 8'b11111_000, 2'd0);

        // branch beats load-use and jump
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_jump = 1'b1; mem_branch_taken = 1'b1;
        step("br_win", 8'b11111_111, 2'd0);
        mem_branch_taken = 1'b0;
        step("lu_jump", 8'b00111_010, 2'd0);
        idle();
        id_jump = 1'b1;
        step("jump", 8'b11111_100, 2'd0);
        idle();

        // zero-wait access
        mem_access = 1'b1; dmem_ready = 1'b1;
        step("mem0", 8'b11111_000, 2'd0);

        // 3 not-ready cycles, freeze overrides a taken branch
        dmem_ready = 1'b0; mem_branch_taken = 1'b1;
        step("mw1", 8'b00000_000, 2'd0);
        mem_branch_taken = 1'b0;
        step("mw2", 8'b00000_000, 2'd1);
        step("mw3", 8'b00000_000, 2'd1);
        dmem_ready = 1'b1;
        step("mw_done", 8'b00001_000, 2'd1);
        idle();
        chk("mw.tmo", 32'(mem_timeout), 32'd0);
        step("mw_run", 8'b11111_000, 2'd0);

        // watchdog: trips on the edge after the 4th not-ready cycle
        mem_access = 1'b1; dmem_ready = 1'b0;
        step("wd1", 8'b00000_000, 2'd0);
        step("wd2", 8'b00000_000, 2'd1);
        step("wd3", 8'b00000_000, 2'd1);
        chk("wd3.tmo", 32'(mem_timeout), 32'd0);
        step("wd4", 8'b00000_000, 2'd1);
        chk("wd.tmo", 32'(mem_timeout), 32'd1);
        step("wd_hold", 8'b00000_000, 2'd2);
        dmem_ready = 1'b1;
        step("wd_done", 8'b00001_000, 2'd2);
        idle();
        chk("wd.sticky", 32'(mem_timeout), 32'd1);
        step("wd_run", 8'b11111_000, 2'd0);

`ifdef HAZ_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
`endif

        // reset mid-wait
        mem_access = 1'b1; dmem_ready = 1'b0;
        step("rw1", 8'b00000_000, 2'd0);
        mem_access = 1'b0;
        res = 1'b0;
        #2;
        chk("rw.st", 32'(state), 32'd0);
        chk("rw.tmo", 32'(mem_timeout), 32'd0);
        chk("rw.ctl", 32'(ctl), 32'h0F8);
`ifdef HAZ_PERF_CNT_EN
        chk("rw.stall", 32'(stall_cnt), 32'd0);
        chk("rw.flush", 32'(flush_cnt), 32'd0);
`endif
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 8'b11111_000, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
